sram_arbiter_2p: RTL and testbench

- Two-port round-robin arbiter and sequencer in front of the sram_1Mx8 controller.
- Accepts word read/write requests from two requesters and presents one access at a time on the controller's i_write/i_addr/i_data.
- Holds each access for a fixed number of cycles, captures the read data and returns a completion pulse to the winning requester.
- Sits between the user logic (e.g. blinky/test logic) and sram_1Mx8.

---
 rtl/sram_arbiter_2p.sv | 136 +++++++++++++
 tb/tb_sram_arbiter_2p.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_2p.sv
// rtl/sram_arbiter_2p.sv - two-port round-robin arbiter and access sequencer for sram_1Mx8
module sram_arbiter_2p #(
   parameter int ADDR_WIDTH    = 20,
   parameter int DATA_WIDTH    = 8,
   parameter int ACCESS_CYCLES = 4
) (
   input  logic                  i_clk,
   input  logic                  i_n_reset,
   input  logic                  i_req0,
   input  logic                  i_req1,
   input  logic                  i_we0,
   input  logic                  i_we1,
   input  logic [ADDR_WIDTH-1:0] i_addr0,
   input  logic [ADDR_WIDTH-1:0] i_addr1,
   input  logic [DATA_WIDTH-1:0] i_wdata0,
   input  logic [DATA_WIDTH-1:0] i_wdata1,
   output logic                  o_gnt0,
   output logic                  o_gnt1,
   output logic                  o_done0,
   output logic                  o_done1,
   output logic [DATA_WIDTH-1:0] o_rdata0,
   output logic [DATA_WIDTH-1:0] o_rdata1,
   output logic                  o_s_write,
   output logic [ADDR_WIDTH-1:0] o_s_addr,
   output logic [DATA_WIDTH-1:0] o_s_data,
   input  logic [DATA_WIDTH-1:0] i_s_data
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   localparam logic [3:0] LAST_COUNT = 4'(ACCESS_CYCLES - 1);

   state_t                r_state, w_state_nxt;
   logic [3:0]            r_count, w_count_nxt;
   logic                  r_pref, w_pref_nxt;   // port favoured on a tie
   logic                  r_port, w_port_nxt;   // owner of the current access
   logic                  r_gnt0, r_gnt1, r_done0, r_done1;
   logic                  w_gnt0, w_gnt1, w_done0, w_done1;
   logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1, w_rdata0, w_rdata1;
   logic                  r_s_write, w_s_write;
   logic [ADDR_WIDTH-1:0] r_s_addr, w_s_addr;
   logic [DATA_WIDTH-1:0] r_s_data, w_s_data;
   logic                  w_win;

   assign w_win = (i_req0 && i_req1) ? r_pref : i_req1;

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_pref_nxt  = r_pref;
      w_port_nxt  = r_port;
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_done0     = 1'b0;
      w_done1     = 1'b0;
      w_rdata0    = r_rdata0;
      w_rdata1    = r_rdata1;
      w_s_write   = r_s_write;
      w_s_addr    = r_s_addr;
      w_s_data    = r_s_data;
      case (r_state)
         S_IDLE: begin
            w_s_write = 1'b0;
            if (i_req0 || i_req1) begin
               w_state_nxt = S_ACCESS;
               w_count_nxt = 4'd0;
               w_port_nxt  = w_win;
               w_pref_nxt  = ~w_win;
               w_gnt0      = ~w_win;
               w_gnt1      = w_win;
               w_s_write   = w_win ? i_we1    : i_we0;
               w_s_addr    = w_win ? i_addr1  : i_addr0;
               w_s_data    = w_win ? i_wdata1 : i_wdata0;
            end
         end
         S_ACCESS: begin
            w_count_nxt = r_count + 4'd1;
            if (r_count == LAST_COUNT) begin
               if (!r_s_write) begin
                  if (r_port) w_rdata1 = i_s_data;
                  else        w_rdata0 = i_s_data;
               end
               w_state_nxt = S_DONE;
               w_s_write   = 1'b0;
               w_done0     = ~r_port;
               w_done1     = r_port;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_n_reset) begin
      if (!i_n_reset) begin
         r_state   <= S_IDLE;
         r_count   <= 4'd0;
         r_pref    <= 1'b0;
         r_port    <= 1'b0;
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_done0   <= 1'b0;
         r_done1   <= 1'b0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
         r_s_write <= 1'b0;
         r_s_addr  <= '0;
         r_s_data  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_pref    <= w_pref_nxt;
         r_port    <= w_port_nxt;
         r_gnt0    <= w_gnt0;
         r_gnt1    <= w_gnt1;
         r_done0   <= w_done0;
         r_done1   <= w_done1;
         r_rdata0  <= w_rdata0;
         r_rdata1  <= w_rdata1;
         r_s_write <= w_s_write;
         r_s_addr  <= w_s_addr;
         r_s_data  <= w_s_data;
      end
   end

   assign o_gnt0    = r_gnt0;
   assign o_gnt1    = r_gnt1;
   assign o_done0   = r_done0;
   assign o_done1   = r_done1;
   assign o_rdata0  = r_rdata0;
   assign o_rdata1  = r_rdata1;
   assign o_s_write = r_s_write;
   assign o_s_addr  = r_s_addr;
   assign o_s_data  = r_s_data;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// tb/tb_sram_arbiter_2p.sv - self-checking bench for sram_arbiter_2p
module tb_sram_arbiter_2p;

   localparam int AC = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
   logic [19:0] addr0 = '0, addr1 = '0;
   logic [7:0]  wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, done0, done1, s_write;
   logic [7:0]  rdata0, rdata1, s_data, s_rdata;
   logic [19:0] s_addr;

   logic        b_req0 = 0;
   logic        b_gnt0, b_gnt1, b_done0, b_done1, b_s_write;
   logic [7:0]  b_rdata0, b_rdata1, b_s_data, b_s_rdata;
   logic [19:0] b_s_addr;

   always #5 clk = ~clk;

   // SRAM content is a fixed function of the address
   function automatic logic [7:0] mem_f(input logic [19:0] a);
      return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'hB5;
   endfunction

   assign s_rdata   = mem_f(s_addr);
   assign b_s_rdata = mem_f(b_s_addr);

   sram_arbiter_2p #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .ACCESS_CYCLES(AC)) dut (
      .i_clk(clk), .i_n_reset(rst_n),
      .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
      .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
      .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
      .o_rdata0(rdata0), .o_rdata1(rdata1),
      .o_s_write(s_write), .o_s_addr(s_addr), .o_s_data(s_data), .i_s_data(s_rdata)
   );

   sram_arbiter_2p #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .ACCESS_CYCLES(1)) dut_b (
      .i_clk(clk), .i_n_reset(rst_n),
      .i_req0(b_req0), .i_req1(1'b0), .i_we0(1'b0), .i_we1(1'b0),
      .i_addr0(20'h00010), .i_addr1(20'h0), .i_wdata0(8'h0), .i_wdata1(8'h0),
      .o_gnt0(b_gnt0), .o_gnt1(b_gnt1), .o_done0(b_done0), .o_done1(b_done1),
      .o_rdata0(b_rdata0), .o_rdata1(b_rdata1),
      .o_s_write(b_s_write), .o_s_addr(b_s_addr), .o_s_data(b_s_data), .i_s_data(b_s_rdata)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // transaction-level reference model: edge count, grant edge, next sample edge
   int          n = 0;
   int          e0, next_sample, pref, mport;
   logic        mwe;
   logic [19:0] maddr;
   logic [7:0]  mwdata;
   logic [7:0]  exp_rdata [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
      end
   endtask

   task automatic model_reset();
      e0 = -1000; next_sample = 0; pref = 0; mport = 0;
      mwe = 1'b0; maddr = '0; mwdata = '0;
      exp_rdata[0] = '0; exp_rdata[1] = '0;
   endtask

   task automatic model_edge();
      int w;
      n++;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (n == e0 + AC && !mwe) exp_rdata[mport] = mem_f(maddr);
      if (n >= next_sample && (req0 || req1)) begin
         w = (req0 && req1) ? pref : (req1 ? 1 : 0);
         pref = 1 - w;
         mport = w;
         mwe    = w ? we1 : we0;
         maddr  = w ? addr1 : addr0;
         mwdata = w ? wdata1 : wdata0;
         e0 = n;
         next_sample = n + AC + 2;
      end
   endtask

   task automatic check_all();
      chk("gnt0",   gnt0,   n == e0 && mport == 0);
      chk("gnt1",   gnt1,   n == e0 && mport == 1);
      chk("done0",  done0,  n == e0 + AC && mport == 0);
      chk("done1",  done1,  n == e0 + AC && mport == 1);
      chk("s_write", s_write, mwe && n >= e0 && n < e0 + AC);
      chk("s_addr", s_addr, maddr);
      chk("s_data", s_data, mwdata);
      chk("rdata0", rdata0, exp_rdata[0]);
      chk("rdata1", rdata1, exp_rdata[1]);
      chk("gnt_excl", gnt0 & gnt1, 0);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int k);
      req0 = 0; req1 = 0;
      for (int i = 0; i < k; i++) cycle();
   endtask

   typedef struct {
      logic        r0, r1, w0, w1;
      logic [19:0] a0, a1;
      logic [7:0]  d0, d1;
      int          exp_port;
      int          exp_wcyc;
      logic [7:0]  exp_rd;
   } vec_t;

   vec_t tbl [4];

   initial begin
      int gp, wc, cnt_g, cnt_d, last_c, last_p;
      tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 20'h00000, 20'hFFFFF, 8'h00, 8'h3C, 1, 4, 8'h00};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 20'h12345, 20'h00200, 8'h00, 8'h00, 0, 0, 8'hD2};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 20'h12345, 20'h00200, 8'h00, 8'h00, 1, 0, 8'hB7};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 20'h00001, 20'h00000, 8'h77, 8'h00, 0, 4, 8'hD2};

      model_reset();
      for (int i = 0; i < 3; i++) cycle();
      rst_n = 1'b1;
      idle(2);

      // port 0 read, fixed latency
      req0 = 1; we0 = 0; addr0 = 20'h00010;
      cycle();
      chk("t1_gnt0", gnt0, 1);
      req0 = 0;
      for (int i = 0; i < 3; i++) cycle();
      cycle();
      chk("t1_done0", done0, 1);
      chk("t1_rdata0", rdata0, 8'hA5);
      cycle();

      foreach (tbl[v]) begin
         req0 = tbl[v].r0; req1 = tbl[v].r1; we0 = tbl[v].w0; we1 = tbl[v].w1;
         addr0 = tbl[v].a0; addr1 = tbl[v].a1; wdata0 = tbl[v].d0; wdata1 = tbl[v].d1;
         gp = -1; wc = 0;
         for (int k = 0; k < AC + 2; k++) begin
            cycle();
            if (gnt0) gp = 0;
            if (gnt1) gp = 1;
            wc += int'(s_write);
            if (k == 0) begin req0 = 0; req1 = 0; end
         end
         chk("tbl_port", gp, tbl[v].exp_port);
         chk("tbl_wcyc", wc, tbl[v].exp_wcyc);
         chk("tbl_rdata", tbl[v].exp_port == 1 ? rdata1 : rdata0, tbl[v].exp_rd);
      end

      // both ports held continuously: alternate, one grant per AC+2 cycles
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; cnt_g = 0; last_c = 0; last_p = 0;
      for (int c = 1; c <= 24; c++) begin
         cycle();
         if (gnt0 || gnt1) begin
            if (cnt_g == 0) chk("t3_first_port", gnt1, 1);
            else begin
               chk("t3_spacing", c - last_c, AC + 2);
               chk("t3_alternate", gnt1, !last_p);
            end
            last_c = c; last_p = gnt1; cnt_g++;
         end
      end
      chk("t3_grants", cnt_g, 4);
      idle(3);

      // port 0 pulse during a port 1 access is never served
      req1 = 1; we1 = 0; addr1 = 20'h00300; cnt_g = 0; cnt_d = 0;
      cycle(); req1 = 0;
      cycle(); req0 = 1; we0 = 1; addr0 = 20'h00555;
      cycle(); req0 = 0;
      for (int i = 0; i < 6; i++) begin
         cnt_g += int'(gnt0); cnt_d += int'(done0);
         cycle();
      end
      chk("t6_no_gnt0", cnt_g, 0);
      chk("t6_no_done0", cnt_d, 0);

      // asynchronous reset during a write access
      req0 = 1; we0 = 1; addr0 = 20'h00ABC; wdata0 = 8'h5A;
      cycle(); req0 = 0;
      cycle(); cycle();
      chk("t4_write_before", s_write, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_async_write", s_write, 0);
      chk("t4_async_addr", s_addr, 0);
      model_reset();
      cnt_d = 0;
      for (int i = 0; i < 3; i++) begin cycle(); cnt_d += int'(done0); end
      rst_n = 1'b1;
      req1 = 1; we1 = 0; addr1 = 20'h00010;
      cycle(); req1 = 0;
      for (int i = 0; i < AC + 1; i++) begin cycle(); cnt_d += int'(done0) + 8 * int'(done1); end
      chk("t4_done_after_reset", cnt_d, 8);
      chk("t4_rdata1", rdata1, 8'hA5);

      // randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         cycle();
         if (n == e0 && mport == 0) begin
            req0 = 1'($urandom_range(0, 1));
            we0 = 1'($urandom_range(0, 1)); addr0 = 20'($urandom); wdata0 = 8'($urandom);
         end else if (!req0 && $urandom_range(0, 3) == 0) begin
            req0 = 1; we0 = 1'($urandom_range(0, 1)); addr0 = 20'($urandom); wdata0 = 8'($urandom);
         end else if (req0 && $urandom_range(0, 15) == 0) req0 = 0;
         if (n == e0 && mport == 1) begin
            req1 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1)); addr1 = 20'($urandom); wdata1 = 8'($urandom);
         end else if (!req1 && $urandom_range(0, 3) == 0) begin
            req1 = 1; we1 = 1'($urandom_range(0, 1)); addr1 = 20'($urandom); wdata1 = 8'($urandom);
         end else if (req1 && $urandom_range(0, 15) == 0) req1 = 0;
      end
      idle(8);

      // single-cycle access build: grant, done next cycle, every 3 cycles
      b_req0 = 1;
      for (int i = 1; i <= 10; i++) begin
         cycle();
         chk("b_gnt0", b_gnt0, (i % 3) == 1);
         chk("b_done0", b_done0, (i % 3) == 2);
         chk("b_other", {b_gnt1, b_done1, b_s_write}, 0);
         if (i == 2) chk("b_rdata0", b_rdata0, 8'hA5);
      end
      b_req0 = 0;
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
